conv_pad_feeder: RTL and testbench
==================================

Name: conv_pad_feeder

Overview:
- Source end of the FP32 streaming convolution interface: drives the convolution engine's reset, then its 32-bit data input.
- Accepts a kernel and a raw N×N image over a valid/ready word stream and buffers the whole frame.
- Then emits an uninterrupted stream, one word per cycle: M×M kernel words, followed by the image zero-padded to (N+2P)×(N+2P) in row-major order.
- Sits between the host/DMA side and the convolution engine, which is configured with n = N+2P, m = M.

Parameters:
- N, 3, raw image dimension (square).
- M, 2, kernel dimension (square); must satisfy M ≤ N+2P.
- P, 1, zero-pad width on each side; P = 0 is legal (no padding).
- NP, N+2*P, padded dimension (derived localparam; not overridable).

Ports:
- clock  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  32  FP32 word from the host: kernel words first, then image words, row-major.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  feeder accepts a word this cycle.
- conv_rst  out  1  reset to the convolution engine (registered).
- a_out  out  32  FP32 word to the convolution engine (registered).
- a_valid  out  1  a_out carries a stream word this cycle (registered).
- conv_end  in  1  end-of-convolution pulse from the engine.
- busy  out  1  high in STREAM_K, STREAM_I and WAIT_END.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values: in_ready=0, conv_rst=1, a_out=32'h0, a_valid=0, busy=0, done=0; state=LOAD_K; all counters cleared.
- in_ready becomes 1 in the first cycle after rst deasserts.
- rst mid-operation aborts the frame: return to LOAD_K and discard partial loads; conv_rst is 1 in the cycle after reset.
- A word transfers only when in_valid & in_ready. in_valid with in_ready=0 is ignored; in_data may change freely.
- LOAD_K:
  - in_ready=1, conv_rst=1.
  - Store accepted words in kreg[0..M*M-1] in arrival order.
  - After the M*M-th accept, go to LOAD_I.
- LOAD_I:
  - in_ready=1, conv_rst=1.
  - Write accepted words to the image buffer at addresses 0..N*N-1.
  - On the N*N-th accept, go to STREAM_K.
  - in_ready drops to 0 in the cycle after that last accept.
- STREAM_K:
  - M*M cycles; conv_rst=0, a_valid=1.
  - In cycle k (k=0 for the first STREAM_K cycle), a_out=kreg[k].
  - Required timing: conv_rst is 1 in the cycle before the first STREAM_K cycle and 0 in that first cycle, so the engine samples kreg[0] at count 0.
  - Then go to STREAM_I.
- STREAM_I:
  - NP*NP cycles; a_valid=1.
  - Position (r,c) with r,c in 0..NP-1 is walked row-major, using row/column counters with wrap (no multipliers).
  - Padding: if r<P, or r≥P+N, or c<P, or c≥P+N, then a_out=32'h0 (FP32 +0).
  - Otherwise a_out = image[(r-P)*N+(c-P)].
  - There are no gaps between the last kernel word and the first image word.
  - The buffer has synchronous read, so the read address is issued one cycle ahead; the output must still have zero gaps.
- WAIT_END:
  - a_valid=0, a_out=0, conv_rst=0.
  - On conv_end=1: pulse done for 1 cycle, set conv_rst=1, go to LOAD_K.
  - in_ready=1 from the following cycle.
- conv_end outside WAIT_END is ignored.
- If conv_end arrives in the same cycle that STREAM_I ends, it is ignored; the feeder then waits for the next pulse.
- Frame length: M*M + NP*NP consecutive valid cycles (defaults: 4 + 25 = 29).

Decomposition:
- Shared package conv_pkg:
  - FP32 zero constant FP_ZERO = 32'h0000_0000.
  - Word width 32.
  - State encoding of conv_fsm_t: LOAD_K, LOAD_I, STREAM_K, STREAM_I, WAIT_END.
  - Helper function for the padded dimension.
- One sub-module: conv_img_buf, a simple dual-port RAM.
  - Parameters DEPTH=N*N and WIDTH=32.
  - Write port driven by the load side; synchronous-read port driven by the stream side.
- Kernel registers stay in the top level.

Test Plan:
- Defaults: kernel 1.0,2.0,3.0,4.0 (32'h3F800000, 40000000, 40400000, 40800000); image 1.0..9.0 with in_valid held high.
  - Required: a_out = kernel words, then 25 words: row 0 all zero, row 1 = 0,1.0,2.0,3.0,0, rows 2–3 likewise, row 4 all zero.
  - a_valid high for exactly 29 consecutive cycles.
  - conv_rst falls exactly in the cycle kreg[0] is presented.
- Host throttling: in_valid toggles 1010… through the load, with in_data junk while in_valid=0.
  - Required: streamed output is identical to the first test; in_ready drops only after the 13th accept.
- P=0, N=3, M=2:
  - Required: stream is 4 kernel words then 9 image words unchanged; no zeros inserted.
- Completion: in WAIT_END, assert conv_end at the 40th cycle after the stream ends.
  - Required: done=1 for one cycle, conv_rst=1 next cycle, in_ready=1, and a second frame loads and streams correctly.
- Abort: rst asserted at stream image word 10, then a full new frame loaded.
  - Required: a_valid=0, conv_rst=1 the cycle after rst; the new frame streams from kreg[0] with no residue of the old one.
- Stray conv_end: pulse it during LOAD_I and during STREAM_I.
  - Required: no state change, no done pulse; the frame completes normally on the later conv_end.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the FP32 convolution feeder path.
// Holds the word type, the feeder FSM encoding and small sizing helpers.
package conv_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        LOAD_K,
        LOAD_I,
        STREAM_K,
        STREAM_I,
        WAIT_END
    } conv_fsm_t;

    function automatic int pad_dim(input int n, input int p);
        return n + 2 * p;
    endfunction

    // Bits needed to index range_max distinct values (never less than one).
    function automatic int cnt_w(input int range_max);
        return (range_max > 1) ? $clog2(range_max) : 1;
    endfunction

endpackage

// File: rtl/conv_img_buf.sv
// Simple dual-port image buffer: write port on the load side,
// synchronous-read port on the stream side.
module conv_img_buf
    import conv_pkg::*;
#(
    parameter int DEPTH = 9,
    parameter int WIDTH = WORD_W
) (
    input  logic                    clock,
    input  logic                    wr_en,
    input  logic [cnt_w(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [cnt_w(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]        rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays get no reset; every location is written during a
    // load before the stream side can read it, so a reset would only add cost.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/conv_pad_feeder.sv
// Source end of the FP32 convolution stream: buffers a kernel and an N x N
// frame, then emits the kernel followed by the zero-padded image gap-free.
module conv_pad_feeder
    import conv_pkg::*;
#(
    parameter int N = 3,
    parameter int M = 2,
    parameter int P = 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              conv_rst,
    output logic [WORD_W-1:0] a_out,
    output logic              a_valid,
    input  logic              conv_end,
    output logic              busy,
    output logic              done
);

    localparam int NP = pad_dim(N, P);
    localparam int KN = M * M;
    localparam int IN = N * N;
    localparam int KW = cnt_w(KN);
    localparam int AW = cnt_w(IN);
    localparam int RW = cnt_w(NP + 1);

    localparam logic [KW-1:0] K_LAST = KW'(KN - 1);
    localparam logic [AW-1:0] I_LAST = AW'(IN - 1);
    localparam logic [RW-1:0] R_LAST = RW'(NP - 1);
    localparam logic [RW-1:0] PAD    = RW'(P);
    localparam logic [RW-1:0] N_R    = RW'(N);

    conv_fsm_t     state, state_n;
    word_t         kreg [KN];
    logic [KW-1:0] k_cnt;
    logic [AW-1:0] i_addr, img_ptr, img_ptr_n;
    logic [RW-1:0] row, col;
    word_t         rd_data, a_out_n;
    logic          accept, img_wr, row_in, col_in, interior, leave_wait;
    logic          a_valid_n, conv_rst_n, done_n;

    assign accept = in_valid & in_ready;
    assign img_wr = (state == LOAD_I) && accept;

    // Offsetting by P wraps pad rows/cols above the image to large values,
    // so one unsigned compare covers both borders.
    assign row_in   = RW'(row - PAD) < N_R;
    assign col_in   = RW'(col - PAD) < N_R;
    assign interior = (state == STREAM_I) && row_in && col_in;

    // The final stream word is still on a_out in the first WAIT_END cycle;
    // an end pulse that early belongs to the engine's previous activity.
    assign leave_wait = (state == WAIT_END) && conv_end && !a_valid;

    // The read address is the pointer value for the next cycle, which
    // absorbs the one-cycle RAM latency without a gap in the stream.
    assign img_ptr_n = !interior          ? img_ptr :
                       (img_ptr == I_LAST) ? '0      : img_ptr + 1'b1;

    assign busy = (state == STREAM_K) || (state == STREAM_I) || (state == WAIT_END);

    // NOTE: combinational logic uses blocking '=' with every target given a
    // default first, so no path can leave a value held and infer a latch.
    always_comb begin
        state_n    = state;
        a_out_n    = FP_ZERO;
        a_valid_n  = 1'b0;
        conv_rst_n = 1'b0;
        done_n     = 1'b0;
        unique case (state)
            LOAD_K: begin
                conv_rst_n = 1'b1;
                if (accept && k_cnt == K_LAST) state_n = LOAD_I;
            end
            LOAD_I: begin
                conv_rst_n = 1'b1;
                if (accept && i_addr == I_LAST) state_n = STREAM_K;
            end
            STREAM_K: begin
                a_valid_n = 1'b1;
                a_out_n   = kreg[k_cnt];
                if (k_cnt == K_LAST) state_n = STREAM_I;
            end
            STREAM_I: begin
                a_valid_n = 1'b1;
                a_out_n   = interior ? rd_data : FP_ZERO;
                if (row == R_LAST && col == R_LAST) state_n = WAIT_END;
            end
            WAIT_END: begin
                if (leave_wait) begin
                    state_n    = LOAD_K;
                    conv_rst_n = 1'b1;
                    done_n     = 1'b1;
                end
            end
            default: state_n = LOAD_K;
        endcase
    end

    // NOTE: registered state uses non-blocking '<=' so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= LOAD_K;
            k_cnt    <= '0;
            i_addr   <= '0;
            row      <= '0;
            col      <= '0;
            img_ptr  <= '0;
            in_ready <= 1'b0;
            conv_rst <= 1'b1;
            a_out    <= FP_ZERO;
            a_valid  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            in_ready <= (state_n == LOAD_K) || (state_n == LOAD_I);
            conv_rst <= conv_rst_n;
            a_out    <= a_out_n;
            a_valid  <= a_valid_n;
            done     <= done_n;
            img_ptr  <= img_ptr_n;
            if ((state == LOAD_K && accept) || state == STREAM_K) begin
                k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
            end
            if (img_wr) begin
                i_addr <= (i_addr == I_LAST) ? '0 : i_addr + 1'b1;
            end
            if (state == STREAM_I) begin
                if (col == R_LAST) begin
                    col <= '0;
                    row <= (row == R_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == LOAD_K && accept) begin
            kreg[k_cnt] <= in_data;
        end
    end

    conv_img_buf #(
        .DEPTH (IN),
        .WIDTH (WORD_W)
    ) u_img_buf (
        .clock   (clock),
        .wr_en   (img_wr),
        .wr_addr (i_addr),
        .wr_data (in_data),
        .rd_addr (img_ptr_n),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_conv_pad_feeder.sv
// Bench for conv_pad_feeder: a padded (P=1) and an unpadded (P=0) instance
// share one host stimulus and are compared against a frame-level model.
module tb_conv_pad_feeder;

    localparam int N   = 3;
    localparam int M   = 2;
    localparam int P   = 1;
    localparam int KN  = M * M;
    localparam int NP1 = N + 2 * P;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        conv_end = 1'b0;

    logic        in_ready1, conv_rst1, a_valid1, busy1, done1;
    logic [31:0] a_out1;
    logic        in_ready0, conv_rst0, a_valid0, busy0, done0;
    logic [31:0] a_out0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    conv_pad_feeder #(.N(N), .M(M), .P(P)) dut1 (
        .clock    (clock),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready1),
        .conv_rst (conv_rst1),
        .a_out    (a_out1),
        .a_valid  (a_valid1),
        .conv_end (conv_end),
        .busy     (busy1),
        .done     (done1)
    );

    conv_pad_feeder #(.N(N), .M(M), .P(0)) dut0 (
        .clock    (clock),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready0),
        .conv_rst (conv_rst0),
        .a_out    (a_out0),
        .a_valid  (a_valid0),
        .conv_end (conv_end),
        .busy     (busy0),
        .done     (done0)
    );

    // Frame contents and expected streams
    logic [31:0] kern [KN];
    logic [31:0] img  [N*N];
    logic [31:0] exp1 [$];
    logic [31:0] exp0 [$];

    // Monitor state, sampled on the falling edge
    logic [31:0] q1 [$];
    logic [31:0] q0 [$];
    int   runs1 = 0, runs0 = 0, run_len1 = 0, run_len0 = 0, cur1 = 0, cur0 = 0;
    int   done_cnt1 = 0, done_cnt0 = 0;
    logic prev_v1 = 1'b0, prev_v0 = 1'b0, prev_cr1 = 1'b1, prev_cr0 = 1'b1;
    logic start_cr1 = 1'b1, start_pre_cr1 = 1'b0, start_cr0 = 1'b1, start_pre_cr0 = 1'b0;

    always @(negedge clock) begin
        if (a_valid1) begin
            if (!prev_v1) begin
                start_cr1     = conv_rst1;
                start_pre_cr1 = prev_cr1;
            end
            q1.push_back(a_out1);
            cur1++;
        end else if (prev_v1) begin
            run_len1 = cur1;
            cur1     = 0;
            runs1++;
        end
        if (a_valid0) begin
            if (!prev_v0) begin
                start_cr0     = conv_rst0;
                start_pre_cr0 = prev_cr0;
            end
            q0.push_back(a_out0);
            cur0++;
        end else if (prev_v0) begin
            run_len0 = cur0;
            cur0     = 0;
            runs0++;
        end
        if (done1) done_cnt1++;
        if (done0) done_cnt0++;
        prev_v1  = a_valid1;
        prev_v0  = a_valid0;
        prev_cr1 = conv_rst1;
        prev_cr0 = conv_rst0;
    end

    task automatic check_word(input string tag, input int idx, input logic [31:0] obs,
                              input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s[%0d]: observed %h, expected %h", tag, idx, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_default();
        for (int i = 0; i < KN; i++) kern[i] = 32'h3F80_0000 + 32'(i) * 32'h0080_0000;
        kern[0] = 32'h3F80_0000;
        kern[1] = 32'h4000_0000;
        kern[2] = 32'h4040_0000;
        kern[3] = 32'h4080_0000;
        img[0] = 32'h3F80_0000; img[1] = 32'h4000_0000; img[2] = 32'h4040_0000;
        img[3] = 32'h4080_0000; img[4] = 32'h40A0_0000; img[5] = 32'h40C0_0000;
        img[6] = 32'h40E0_0000; img[7] = 32'h4100_0000; img[8] = 32'h4110_0000;
    endtask

    task automatic set_random();
        for (int i = 0; i < KN; i++) kern[i] = $urandom;
        for (int i = 0; i < N*N; i++) img[i] = $urandom;
    endtask

    // Reference: kernel words, then the padded frame walked row-major.
    task automatic build_expected();
        exp1.delete();
        exp0.delete();
        for (int k = 0; k < KN; k++) begin
            exp1.push_back(kern[k]);
            exp0.push_back(kern[k]);
        end
        for (int r = 0; r < NP1; r++) begin
            for (int c = 0; c < NP1; c++) begin
                if (r < P || r >= P + N || c < P || c >= P + N) exp1.push_back(32'h0);
                else exp1.push_back(img[(r - P) * N + (c - P)]);
            end
        end
        for (int i = 0; i < N*N; i++) exp0.push_back(img[i]);
    endtask

    task automatic load_frame(input string tag, input bit throttle, input int stray_at);
        int stalls;
        logic [31:0] w;
        stalls = 0;
        q1.delete();
        q0.delete();
        build_expected();
        for (int i = 0; i < KN + N*N; i++) begin
            w = (i < KN) ? kern[i] : img[i - KN];
            in_valid = 1'b1;
            in_data  = w;
            conv_end = (i == stray_at);
            while (!in_ready1 && stalls < 50) begin
                stalls++;
                step();
            end
            step();
            conv_end = 1'b0;
            if (i == KN + N*N - 1) begin
                check_bit({tag, "_ready_drop_p1"}, in_ready1, 1'b0);
                check_bit({tag, "_ready_drop_p0"}, in_ready0, 1'b0);
            end
            if (throttle) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                step();
            end
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        check_word({tag, "_load_stalls"}, 0, stalls, 0);
    endtask

    task automatic wait_words(input string tag, input int n);
        int t;
        t = 0;
        while (q1.size() < n && t < 300) begin
            t++;
            step();
        end
        check_bit({tag, "_reach_word"}, q1.size() >= n, 1'b1);
    endtask

    task automatic wait_stream(input string tag);
        int start, t;
        start = runs1;
        t = 0;
        while (runs1 == start && t < 300) begin
            t++;
            step();
        end
        check_bit({tag, "_stream_end"}, runs1 != start, 1'b1);
    endtask

    task automatic compare_streams(input string tag);
        check_word({tag, "_len_p1"}, 0, q1.size(), exp1.size());
        for (int i = 0; i < exp1.size(); i++)
            check_word({tag, "_word_p1"}, i, (i < q1.size()) ? q1[i] : 32'hxxxx_xxxx, exp1[i]);
        check_word({tag, "_len_p0"}, 0, q0.size(), exp0.size());
        for (int i = 0; i < exp0.size(); i++)
            check_word({tag, "_word_p0"}, i, (i < q0.size()) ? q0[i] : 32'hxxxx_xxxx, exp0[i]);
        check_word({tag, "_run_p1"}, 0, run_len1, exp1.size());
        check_word({tag, "_run_p0"}, 0, run_len0, exp0.size());
        check_bit({tag, "_crst_first_p1"}, start_cr1, 1'b0);
        check_bit({tag, "_crst_before_p1"}, start_pre_cr1, 1'b1);
        check_bit({tag, "_crst_first_p0"}, start_cr0, 1'b0);
        check_bit({tag, "_crst_before_p0"}, start_pre_cr0, 1'b1);
    endtask

    task automatic end_frame(input string tag);
        int dc1, dc0;
        repeat (38) step();
        check_bit({tag, "_busy_wait_p1"}, busy1, 1'b1);
        check_bit({tag, "_busy_wait_p0"}, busy0, 1'b1);
        check_bit({tag, "_ready_wait"}, in_ready1, 1'b0);
        check_bit({tag, "_valid_wait"}, a_valid1, 1'b0);
        check_bit({tag, "_crst_wait"}, conv_rst1, 1'b0);
        check_word({tag, "_aout_wait"}, 0, a_out1, 32'h0);
        dc1 = done_cnt1;
        dc0 = done_cnt0;
        conv_end = 1'b1;
        step();
        conv_end = 1'b0;
        check_bit({tag, "_done_p1"}, done1, 1'b1);
        check_bit({tag, "_done_p0"}, done0, 1'b1);
        check_bit({tag, "_crst_done"}, conv_rst1, 1'b1);
        check_bit({tag, "_ready_done"}, in_ready1, 1'b1);
        check_bit({tag, "_busy_done"}, busy1, 1'b0);
        step();
        check_bit({tag, "_done_pulse"}, done1, 1'b0);
        check_bit({tag, "_crst_after"}, conv_rst1, 1'b1);
        check_bit({tag, "_ready_after"}, in_ready1, 1'b1);
        check_word({tag, "_done_count_p1"}, 0, done_cnt1 - dc1, 1);
        check_word({tag, "_done_count_p0"}, 0, done_cnt0 - dc0, 1);
    endtask

    initial begin
        int dc1, dc0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check_bit("rst_in_ready", in_ready1, 1'b0);
        check_bit("rst_conv_rst", conv_rst1, 1'b1);
        check_word("rst_a_out", 0, a_out1, 32'h0);
        check_bit("rst_a_valid", a_valid1, 1'b0);
        check_bit("rst_busy", busy1, 1'b0);
        check_bit("rst_done", done1, 1'b0);
        check_bit("rst_busy_p0", busy0, 1'b0);
        rst = 1'b0;
        step();
        check_bit("ready_after_rst", in_ready1, 1'b1);
        check_bit("ready_after_rst_p0", in_ready0, 1'b1);

        // Default frame, in_valid held high
        set_default();
        load_frame("dflt", 1'b0, -1);
        wait_stream("dflt");
        compare_streams("dflt");
        end_frame("dflt");

        // Throttled host with stray conv_end pulses in LOAD_I and STREAM_I
        dc1 = done_cnt1;
        dc0 = done_cnt0;
        set_default();
        load_frame("thr", 1'b1, KN + 2);
        wait_words("thr", KN + 3);
        conv_end = 1'b1;
        step();
        conv_end = 1'b0;
        wait_stream("thr");
        compare_streams("thr");
        check_word("thr_stray_done_p1", 0, done_cnt1 - dc1, 0);
        check_word("thr_stray_done_p0", 0, done_cnt0 - dc0, 0);
        end_frame("thr");

        // Random frame aborted by rst at image word 10
        set_random();
        load_frame("abort", 1'b0, -1);
        wait_words("abort", KN + 10);
        rst = 1'b1;
        step();
        check_bit("abort_valid_p1", a_valid1, 1'b0);
        check_bit("abort_crst_p1", conv_rst1, 1'b1);
        check_bit("abort_ready_p1", in_ready1, 1'b0);
        check_bit("abort_valid_p0", a_valid0, 1'b0);
        check_bit("abort_crst_p0", conv_rst0, 1'b1);
        check_bit("abort_busy_p1", busy1, 1'b0);
        rst = 1'b0;
        step();
        check_bit("abort_ready_back", in_ready1, 1'b1);

        // Fresh random frame after the abort, then a normal completion
        set_random();
        load_frame("post", 1'b0, -1);
        wait_stream("post");
        compare_streams("post");
        end_frame("post");

        // A second random frame back to back
        set_random();
        load_frame("rnd2", 1'b0, -1);
        wait_stream("rnd2");
        compare_streams("rnd2");
        end_frame("rnd2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
